demux_stream_1xn: RTL and testbench
===================================

// Module: demux_stream_1xn
//
// PURPOSE
//   Registered 1-to-NCH stream demultiplexer with valid/ready handshake.
//   Routes one WIDTH-bit word per cycle to the output channel named by
//   in_sel, or to all channels when in_bcast is set.
//   Each channel has a one-entry output buffer, so the block sustains full
//   throughput with 1-cycle latency.
//   Sits between the fetch/decode datapath and multiple consumers in the
//   processor.
//
// PARAMETERS
//   WIDTH  8  data word width in bits
//   NCH    4  number of output channels (>=2, need not be a power of 2)
//   SELW   $clog2(NCH) width of in_sel; derived, do not override
//
// PORTS
//   clk        in   1          single clock, rising edge
//   rst_n      in   1          asynchronous reset, active-low
//   in_valid   in   1          input word valid
//   in_ready   out  1          block accepts input this cycle
//   in_data    in   WIDTH      input word
//   in_sel     in   SELW       destination channel index
//   in_bcast   in   1          1 = deliver to all channels, in_sel ignored
//   out_valid  out  NCH        per-channel valid
//   out_ready  in   NCH        per-channel ready
//   out_data   out  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
//   err_sel    out  1          sticky: a word was sent to in_sel >= NCH
//   drop_cnt   out  8          count of dropped words, saturates at 255
//
// BEHAVIOUR
//   - Reset: out_valid = 0, out_data = 0, err_sel = 0, drop_cnt = 0.
//     Reset is asynchronous. Buffered words are discarded when reset is
//     asserted, including mid-transfer.
//   - free[k] = !out_valid[k] | out_ready[k].
//     A buffer drained this cycle may be refilled in the same cycle.
//   - in_ready (combinational):
//       bcast          -> AND of free[k] over all k
//       in_sel < NCH   -> free[in_sel]
//       in_sel >= NCH  -> 1
//   - Accept = in_valid & in_ready.
//     On accept, each target buffer loads in_data and sets out_valid[k] = 1
//     on the next edge. Latency is 1 cycle.
//   - Broadcast is all-or-nothing: no channel loads until all are free.
//   - A channel with out_valid & !out_ready holds out_data and out_valid
//     stable.
//     Otherwise, when out_ready[k] = 1 and the channel is not reloaded,
//     out_valid[k] clears on the next edge.
//   - Invalid sel: accept with in_sel >= NCH and !in_bcast drops the word.
//     err_sel sets and stays set until reset.
//     drop_cnt increments by 1 and saturates at 8'hFF.
//   - in_valid = 0: no state change except output drains.
//   - in_sel and in_bcast are sampled only when in_valid = 1.
//   - in_ready is a combinational function of out_ready and out_valid.
//     in_ready must not depend on in_valid.
//
// STRUCTURE
//   - Shared package demux_pkg: clog2 helper function and SELW derivation.
//   - Sub-module demux_slot: one-entry valid/ready buffer
//     (inputs: load, data, out_ready; outputs: free, out_valid, out_data).
//     Instantiated NCH times in a generate loop.
//   - Top level contains only the select decode, the in_ready mux, and the
//     error/drop-count logic.
//
// TESTING
//   1. Reset: assert rst_n = 0 mid-stream with out_valid = 4'b0101.
//      -> out_valid = 0, err_sel = 0, drop_cnt = 0 immediately, without
//         waiting for clk.
//   2. Streaming: out_ready = all 1; send in_sel = 0,1,2,3 with data
//      8'hA0..8'hA3 on consecutive cycles.
//      -> each out_valid[k] pulses one cycle later carrying 8'hA0+k.
//      -> in_ready stays 1 throughout.
//   3. Backpressure: out_ready[2] = 0; send two words to channel 2
//      (8'h11, then 8'h22).
//      -> first word is held on channel 2; in_ready = 0 for the second.
//      -> raise out_ready[2]: 8'h11 drains and 8'h22 loads in the same
//         cycle.
//   4. Broadcast: channel 1 is full with out_ready[1] = 0; send
//      bcast = 1, data = 8'h5A.
//      -> in_ready = 0 and no channel loads.
//      -> release channel 1: all four channels show 8'h5A on the next cycle.
//   5. Invalid select: NCH = 5 build; send in_sel = 6, then in_sel = 7.
//      -> both words accepted and dropped; err_sel = 1, drop_cnt = 2.
//      -> 300 further drops leave drop_cnt at 255.
//   6. Random: constrained-random valid/ready/sel/bcast traffic checked
//      against a per-channel FIFO scoreboard over 10k cycles.
//      -> no loss, no duplication, no reordering per channel.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: default sizing and the
// select-width derivation used by the top level.
package demux_pkg;

  localparam int DEF_WIDTH = 32'sd8;
  localparam int DEF_NCH   = 32'sd4;

  // Smallest r with 2**r >= n; evaluated at elaboration time.
  function automatic int demux_clog2(input int n);
    int r;
    r = 32'sd0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready output buffer. A word drained this cycle can be
// replaced by a new load on the same edge.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic             free,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  assign free = ~out_valid | out_ready;

  // Buffer state: load wins, otherwise drain on ready, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_data  <= out_data;
    end else begin
      out_valid <= out_valid;
      out_data  <= out_data;
    end
  end

endmodule

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-NCH valid/ready demultiplexer with broadcast, dropping
// words addressed beyond the last channel and counting them.
module demux_stream_1xn
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SELW  = demux_clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_bcast,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 err_sel,
  output logic [7:0]           drop_cnt
);

  logic [NCH-1:0] free;
  logic [NCH-1:0] sel_hit;
  logic [NCH-1:0] load;
  logic           sel_ok;
  logic           accept;
  logic           drop;

  // One-hot decode of in_sel; an out-of-range select hits no channel.
  always_comb begin
    sel_hit = {NCH{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      if (in_sel == SELW'(k)) begin
        sel_hit[k] = 1'b1;
      end else begin
        sel_hit[k] = 1'b0;
      end
    end
  end

  assign sel_ok = |sel_hit;

  // Broadcast waits for every buffer; a bad select is always accepted.
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast) begin
      in_ready = &free;
    end else if (sel_ok) begin
      in_ready = |(sel_hit & free);
    end else begin
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~in_bcast & ~sel_ok;

  // Per-channel load strobes.
  always_comb begin
    load = {NCH{1'b0}};
    if (accept && in_bcast) begin
      load = {NCH{1'b1}};
    end else if (accept) begin
      load = sel_hit;
    end else begin
      load = {NCH{1'b0}};
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .data      (in_data),
      .out_ready (out_ready[k]),
      .free      (free[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*WIDTH +: WIDTH])
    );
  end

  // Sticky select error and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel  <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      err_sel  <= 1'b1;
      drop_cnt <= (drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1;
    end else begin
      err_sel  <= err_sel;
      drop_cnt <= drop_cnt;
    end
  end

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Directed and random checks of demux_stream_1xn with a 4-channel and a
// 5-channel instance sharing clock and reset.
module tb_demux_stream_1xn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v4, r4, b4;
  logic [1:0]  s4;
  logic [7:0]  d4;
  logic [3:0]  ov4, or4;
  logic [31:0] od4;
  logic        e4;
  logic [7:0]  c4;

  logic        v5, r5, b5;
  logic [2:0]  s5;
  logic [7:0]  d5;
  logic [4:0]  ov5, or5;
  logic [39:0] od5;
  logic        e5;
  logic [7:0]  c5;

  int checks = 0;
  int errors = 0;

  logic       m_v [4];
  logic [7:0] m_d [4];

  demux_stream_1xn #(.WIDTH(8), .NCH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_data(d4),
    .in_sel(s4), .in_bcast(b4), .out_valid(ov4), .out_ready(or4),
    .out_data(od4), .err_sel(e4), .drop_cnt(c4)
  );

  demux_stream_1xn #(.WIDTH(8), .NCH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5), .in_data(d5),
    .in_sel(s5), .in_bcast(b5), .out_valid(ov5), .out_ready(or5),
    .out_data(od5), .err_sel(e5), .drop_cnt(c5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ch4(input int k);
    return od4[k*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    v4 = 1'b0; b4 = 1'b0; s4 = 2'd0; d4 = 8'd0; or4 = 4'd0;
    v5 = 1'b0; b5 = 1'b0; s5 = 3'd0; d5 = 8'd0; or5 = 5'd0;
    #1;
    chk("rst_ov4", 32'(ov4), 32'h0);
    chk("rst_od4", od4, 32'h0);
    chk("rst_err", 32'(e5), 32'h0);
    chk("rst_cnt", 32'(c5), 32'h0);
    #12 rst_n = 1'b1;
    step();

    // Streaming: one word per cycle to channels 0..3.
    or4 = 4'hF;
    v4  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s4 = 2'(k);
      d4 = 8'hA0 + 8'(k);
      #1;
      chk("stream_rdy", 32'(r4), 32'h1);
      step();
      chk("stream_ov", 32'(ov4), 32'(4'b0001 << k));
      chk("stream_data", 32'(ch4(k)), 32'hA0 + 32'(k));
    end
    v4 = 1'b0;
    step();
    chk("stream_idle", 32'(ov4), 32'h0);

    // Backpressure on channel 2.
    or4 = 4'b1011;
    v4 = 1'b1; s4 = 2'd2; d4 = 8'h11;
    #1;
    chk("bp_rdy1", 32'(r4), 32'h1);
    step();
    chk("bp_ov1", 32'(ov4), 32'h4);
    chk("bp_d1", 32'(ch4(2)), 32'h11);
    d4 = 8'h22;
    #1;
    chk("bp_rdy2", 32'(r4), 32'h0);
    step();
    chk("bp_hold_v", 32'(ov4), 32'h4);
    chk("bp_hold_d", 32'(ch4(2)), 32'h11);
    or4 = 4'hF;
    #1;
    chk("bp_rdy3", 32'(r4), 32'h1);
    step();
    chk("bp_ov2", 32'(ov4), 32'h4);
    chk("bp_d2", 32'(ch4(2)), 32'h22);
    v4 = 1'b0;
    step();
    chk("bp_idle", 32'(ov4), 32'h0);

    // Broadcast blocked by a full channel 1.
    or4 = 4'b1101;
    v4 = 1'b1; s4 = 2'd1; d4 = 8'h33;
    step();
    chk("bc_fill", 32'(ov4), 32'h2);
    b4 = 1'b1; d4 = 8'h5A;
    #1;
    chk("bc_rdy0", 32'(r4), 32'h0);
    step();
    chk("bc_block_v", 32'(ov4), 32'h2);
    chk("bc_block_d", 32'(ch4(1)), 32'h33);
    or4 = 4'hF;
    #1;
    chk("bc_rdy1", 32'(r4), 32'h1);
    step();
    chk("bc_ov", 32'(ov4), 32'hF);
    chk("bc_data", od4, 32'h5A5A5A5A);
    v4 = 1'b0; b4 = 1'b0;
    step();
    chk("bc_idle", 32'(ov4), 32'h0);

    // Invalid select on the 5-channel build.
    or5 = 5'h1F;
    v5 = 1'b1; s5 = 3'd6; d5 = 8'h77;
    #1;
    chk("inv_rdy", 32'(r5), 32'h1);
    step();
    chk("inv_err", 32'(e5), 32'h1);
    chk("inv_cnt1", 32'(c5), 32'h1);
    chk("inv_ov", 32'(ov5), 32'h0);
    s5 = 3'd7;
    step();
    chk("inv_cnt2", 32'(c5), 32'h2);
    repeat (300) step();
    chk("inv_sat", 32'(c5), 32'hFF);
    chk("inv_sticky", 32'(e5), 32'h1);
    s5 = 3'd4; d5 = 8'h44; or5 = 5'b01111;
    step();
    chk("ch4_ov", 32'(ov5), 32'h10);
    chk("ch4_d", 32'(od5[39:32]), 32'h44);
    chk("ch4_rdy", 32'(r5), 32'h0);
    s5 = 3'd6;
    #1;
    chk("inv_rdy_bp", 32'(r5), 32'h1);
    v5 = 1'b0;
    step();
    chk("inv_sat_hold", 32'(c5), 32'hFF);

    // Asynchronous reset with channels 0 and 2 holding words.
    or4 = 4'h0;
    v4 = 1'b1; s4 = 2'd0; d4 = 8'h01;
    step();
    s4 = 2'd2; d4 = 8'h02;
    step();
    v4 = 1'b0;
    chk("pre_rst_ov", 32'(ov4), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov4", 32'(ov4), 32'h0);
    chk("arst_od4", od4, 32'h0);
    chk("arst_ov5", 32'(ov5), 32'h0);
    chk("arst_err", 32'(e5), 32'h0);
    chk("arst_cnt", 32'(c5), 32'h0);
    step();
    #2 rst_n = 1'b1;
    step();

    // Random traffic against a depth-1 per-channel scoreboard.
    for (int k = 0; k < 4; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = 8'd0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [3:0] efree;
      logic       erdy;
      v4 = ($urandom_range(3, 0) != 0);
      b4 = ($urandom_range(7, 0) == 0);
      s4 = 2'($urandom);
      d4 = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        or4[k] = ($urandom_range(3, 0) != 0);
      end
      #1;
      for (int k = 0; k < 4; k++) begin
        efree[k] = ~m_v[k] | or4[k];
      end
      erdy = b4 ? (&efree) : efree[s4];
      chk("rnd_rdy", 32'(r4), 32'(erdy));
      for (int k = 0; k < 4; k++) begin
        chk("rnd_valid", 32'(ov4[k]), 32'(m_v[k]));
        if (m_v[k]) begin
          chk("rnd_data", 32'(ch4(k)), 32'(m_d[k]));
        end
        if (m_v[k] && or4[k]) begin
          m_v[k] = 1'b0;
        end
      end
      if (v4 && erdy) begin
        for (int k = 0; k < 4; k++) begin
          if (b4 || (s4 == 2'(k))) begin
            m_v[k] = 1'b1;
            m_d[k] = d4;
          end
        end
      end
      step();
    end
    v4 = 1'b0;
    chk("rnd_err_clear", 32'(e4), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
